gray_arb_ctrl: RTL and testbench
================================

Name: gray_arb_ctrl

Overview:
Round-robin arbiter and sequencer that shares one binary-to-Gray conversion stage among NREQ requesters. Each requester presents a binary word with a level request. The controller grants one requester at a time, latches its operand and converts it. It then returns a registered Gray result tagged with the source ID, plus a one-cycle acknowledge. It sits between the stimulus/requester logic and the combinational Gray converter.

Parameters:
WIDTH, 4, operand/result width in bits (2..16)
NREQ, 4, number of requesters (2..8)
IDW, 2, source-ID width; must equal clog2(NREQ)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  NREQ  level request per requester; hold high with bin_in stable until ack
bin_in  in  NREQ*WIDTH  flattened operands; requester i in bits [i*WIDTH +: WIDTH]
ack  out  NREQ  one-hot, one-cycle pulse: request i consumed and result valid
gray_out  out  WIDTH  registered Gray code of the granted operand
src_id  out  IDW  index of the requester whose result is on gray_out
valid  out  1  one-cycle pulse, coincident with ack
busy  out  1  high while a conversion is in flight (state CONV)
conv_cnt  out  16  completed-conversion counter; wraps FFFF->0000

Behaviour:
- Interface clocking: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - ack=0, valid=0, busy=0, gray_out=0, src_id=0, conv_cnt=0.
  - State=IDLE; operand register=0.
  - RR pointer last=NREQ-1, so requester 0 has top priority first.
- Conversion rule: gray = bin ^ (bin >> 1), where the MSB passes through unchanged.
- FSM, 2 states:
  - IDLE:
    - Eligible requests are req & ~ack; the requester being acknowledged this cycle is masked.
    - If any request is eligible, pick the first set bit searching from last+1 upward, wrapping modulo NREQ.
    - On that pick: latch its operand and index, set last=winner, go to CONV.
    - If nothing is eligible, stay in IDLE.
  - CONV:
    - Register gray_out=conv(operand) and src_id=winner.
    - Assert valid=1 and ack[winner]=1 for the following cycle; increment conv_cnt.
    - Return to IDLE.
- Latency:
  - A request sampled at edge k produces valid/ack visible after edge k+1, i.e. 2 cycles.
  - Maximum throughput is one result every 2 cycles.
- ack/valid are high for exactly one cycle; gray_out and src_id hold their values until the next completion.
- Requester protocol:
  - Drop req in the cycle after seeing ack, or re-raise it to issue a new request.
  - A requester that keeps req high is re-granted only after the masking cycle, and only in its RR turn.
- Request withdrawn while in CONV: the conversion still completes and the ack is still issued; the requester ignores it.
- Simultaneous requests: RR order is strict. With all NREQ requesting continuously, grants cycle 0,1,2,3,0…, with no starvation.
- Operand is sampled only at grant; bin_in changes after grant do not affect the result.
- Reset mid-CONV: the conversion is aborted, no ack is issued, and all outputs go to reset values on the next edge.
- busy=1 exactly in CONV.

Decomposition:
- Shared package:
  - State encodings ST_IDLE=1'b0 and ST_CONV=1'b1.
  - Default WIDTH/NREQ constants.
  - clog2 function.
- Sub-module gray_conv_n: parameterised purely combinational WIDTH-bit binary-to-Gray converter, instantiated once.
- Arbiter priority search stays inline in gray_arb_ctrl.

Test Plan:
1. Reset: assert rst 3 cycles with req=4'b1111 -> ack=0, valid=0, gray_out=0, conv_cnt=0 throughout.
2. Single request: req=4'b0001, bin_in[3:0]=4'b0101 -> valid/ack=4'b0001 two cycles after sampling; gray_out=4'b0111, src_id=0, conv_cnt=1.
3. Round robin:
   - Stimulus: all req high with operands 0:0110, 1:1011, 2:1111, 3:0011.
   - Required: results in order src 0,1,2,3 = 0101, 1110, 1000, 0010, then src 0 again; one valid every 2 cycles.
4. Masking: req0 held high continuously with req2 high -> grants alternate 0,2,0,2; no back-to-back double grant of 0 in consecutive conversions while req2 is pending.
5. Operand stability and withdraw:
   - Stimulus: grant requester 1 with 1011, then change bin_in to 0000 and drop req1 in CONV.
   - Required: ack[1] still pulses with gray_out=1110.
6. Reset mid-CONV: assert rst in the CONV cycle -> no ack/valid; outputs return to 0; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/gray_arb_ctrl_pkg.sv
// Shared definitions for the round-robin Gray conversion controller.
// Holds the FSM encoding, the default sizes and a constant clog2 helper.
package gray_arb_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/gray_arb_ctrl_gray_conv.sv
// Purely combinational WIDTH-bit binary-to-Gray converter.
// The MSB passes through unchanged because it is XORed with a shifted-in zero.
module gray_conv_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_arb_ctrl.sv
// Round-robin arbiter that shares one Gray converter among NREQ requesters.
// A grant latches the operand in IDLE; CONV registers the result and pulses ack/valid.
module gray_arb_ctrl
  import gray_arb_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] bin_in,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      gray_out,
  output logic [IDW-1:0]        src_id,
  output logic                  valid,
  output logic                  busy,
  output logic [15:0]           conv_cnt
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [IDW-1:0]   src_q, src_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [NREQ-1:0]  elig;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  int               cand_i;
  logic [WIDTH-1:0] op_sel;
  logic [WIDTH-1:0] conv_gray;

  gray_conv_n #(.WIDTH(WIDTH)) u_conv (
    .bin  (op_q),
    .gray (conv_gray)
  );

  // The requester acknowledged last cycle is masked so it cannot be re-granted
  // on the strength of a req it has not yet had a chance to drop.
  always_comb begin
    elig        = req & ~ack_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_i      = 0;
    cand        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_i = int'(last_q) + i;
      if (cand_i >= NREQ) cand_i = cand_i - NREQ;
      cand = IDW'(cand_i);
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    op_sel = bin_in[grant_idx*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    last_d  = last_q;
    ack_d   = '0;
    valid_d = 1'b0;
    gray_d  = gray_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          op_d    = op_sel;
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        gray_d  = conv_gray;
        src_d   = id_q;
        valid_d = 1'b1;
        ack_d   = NREQ'(1) << id_q;
        cnt_d   = cnt_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
      ack_q   <= '0;
      valid_q <= 1'b0;
      gray_q  <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      gray_q  <= gray_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack      = ack_q;
  assign valid    = valid_q;
  assign gray_out = gray_q;
  assign src_id   = src_q;
  assign conv_cnt = cnt_q;
  assign busy     = (state_q == ST_CONV);

endmodule

// File: tb/tb_gray_arb_ctrl.sv
// Bench for gray_arb_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a behavioural model.
module tb_gray_arb_ctrl;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int BW    = NREQ * WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [BW-1:0]     bin_in;
  logic [NREQ-1:0]   ack;
  logic [WIDTH-1:0]  gray_out;
  logic [IDW-1:0]    src_id;
  logic              valid;
  logic              busy;
  logic [15:0]       conv_cnt;

  int total = 0;
  int bad   = 0;

  gray_arb_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .bin_in   (bin_in),
    .ack      (ack),
    .gray_out (gray_out),
    .src_id   (src_id),
    .valid    (valid),
    .busy     (busy),
    .conv_cnt (conv_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   bx;
    logic [WIDTH-1:0] g;
    bx = {1'b0, b};
    for (int i = 0; i < WIDTH; i++) g[i] = bx[i] ^ bx[i+1];
    return g;
  endfunction

  bit               m_en = 1'b0;
  bit               m_inflight;
  int               m_id;
  int               m_last;
  int               m_c;
  bit               m_found;
  logic [WIDTH-1:0] m_op;
  logic [NREQ-1:0]  m_elig;
  logic [NREQ-1:0]  e_ack;
  logic             e_valid;
  logic             e_busy;
  logic [WIDTH-1:0] e_gray;
  int               e_src;
  logic [15:0]      e_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_en       = 1'b1;
      m_inflight = 1'b0;
      m_last     = NREQ - 1;
      m_id       = 0;
      m_op       = '0;
      e_ack      = '0;
      e_valid    = 1'b0;
      e_busy     = 1'b0;
      e_gray     = '0;
      e_src      = 0;
      e_cnt      = '0;
    end else if (m_en) begin
      if (m_inflight) begin
        e_gray     = to_gray(m_op);
        e_src      = m_id;
        e_valid    = 1'b1;
        e_ack      = '0;
        e_ack[m_id] = 1'b1;
        e_cnt      = e_cnt + 16'd1;
        m_inflight = 1'b0;
      end else begin
        m_elig  = req & ~e_ack;
        e_ack   = '0;
        e_valid = 1'b0;
        m_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          m_c = (m_last + k) % NREQ;
          if (!m_found && m_elig[m_c]) begin
            m_found    = 1'b1;
            m_inflight = 1'b1;
            m_id       = m_c;
            m_op       = bin_in[m_c*WIDTH +: WIDTH];
          end
        end
        if (m_found) m_last = m_id;
      end
      e_busy = m_inflight;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_en) begin
      check("cmp_ack",      32'(ack),      32'(e_ack));
      check("cmp_valid",    32'(valid),    32'(e_valid));
      check("cmp_busy",     32'(busy),     32'(e_busy));
      check("cmp_gray_out", 32'(gray_out), 32'(e_gray));
      check("cmp_src_id",   32'(src_id),   32'(e_src));
      check("cmp_conv_cnt", 32'(conv_cnt), 32'(e_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst = 1'b1;
    req = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] v);
    bin_in[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < max) begin
      @(negedge clk);
      cyc++;
      if (valid === 1'b1) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL wait_valid: no valid within %0d cycles, required a pulse", max);
    end
  endtask

  logic [WIDTH-1:0] rr_gray [5] = '{4'b0101, 4'b1110, 4'b1000, 4'b0010, 4'b0101};
  int               rr_src  [5] = '{0, 1, 2, 3, 0};
  int               alt_src [4] = '{0, 2, 0, 2};

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    rst    = 1'b1;
    req    = 4'b1111;
    bin_in = '0;

    // reset held with all requests up
    repeat (3) begin
      @(negedge clk);
      check("t1_ack",   32'(ack),      32'h0);
      check("t1_valid", 32'(valid),    32'h0);
      check("t1_gray",  32'(gray_out), 32'h0);
      check("t1_cnt",   32'(conv_cnt), 32'h0);
    end
    rst = 1'b0;
    req = '0;
    @(negedge clk);

    // single request
    set_op(0, 4'b0101);
    req = 4'b0001;
    wait_valid(10, cyc);
    check("t2_latency", 32'(cyc),      32'd2);
    check("t2_ack",     32'(ack),      32'b0001);
    check("t2_gray",    32'(gray_out), 32'b0111);
    check("t2_src",     32'(src_id),   32'd0);
    check("t2_cnt",     32'(conv_cnt), 32'd1);
    req = '0;

    // round robin over all four
    do_reset(2);
    set_op(0, 4'b0110);
    set_op(1, 4'b1011);
    set_op(2, 4'b1111);
    set_op(3, 4'b0011);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_valid(6, cyc);
      check("t3_spacing", 32'(cyc),      32'd2);
      check("t3_src",     32'(src_id),   32'(rr_src[n]));
      check("t3_gray",    32'(gray_out), 32'(rr_gray[n]));
    end
    req = '0;

    // masking: requester 0 held with requester 2 pending
    do_reset(2);
    set_op(0, 4'b1001);
    set_op(2, 4'b0100);
    req = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      wait_valid(6, cyc);
      check("t4_src", 32'(src_id), 32'(alt_src[n]));
    end
    req = '0;

    // operand changed and request withdrawn during CONV
    do_reset(2);
    set_op(1, 4'b1011);
    req = 4'b0010;
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd1);
    set_op(1, 4'b0000);
    req = '0;
    wait_valid(4, cyc);
    check("t5_latency", 32'(cyc),      32'd1);
    check("t5_ack",     32'(ack),      32'b0010);
    check("t5_gray",    32'(gray_out), 32'b1110);

    // reset during CONV
    do_reset(2);
    set_op(2, 4'b0110);
    req = 4'b0100;
    @(negedge clk);
    check("t6_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    check("t6_valid", 32'(valid),    32'd0);
    check("t6_ack",   32'(ack),      32'd0);
    check("t6_busy0", 32'(busy),     32'd0);
    check("t6_gray",  32'(gray_out), 32'd0);
    check("t6_cnt",   32'(conv_cnt), 32'd0);
    rst = 1'b0;
    wait_valid(6, cyc);
    check("t6_first_src", 32'(src_id), 32'd0);
    req = '0;

    // randomized traffic with occasional resets
    do_reset(2);
    repeat (3000) begin
      @(negedge clk);
      req    = NREQ'($urandom_range(0, 15));
      bin_in = BW'($urandom);
      rst    = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
